// File: rtl/ram4k_stream_fifo.sv
// Valid/ready streaming FIFO controller driving one external 256x16 RAM4K block.
// A two-entry output stage (out + skid) hides the RAM's one-cycle read latency.
module ram4k_stream_fifo #(
   parameter int unsigned DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [15:0] wr_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [15:0] rd_data,
   output logic [8:0]  level,
   output logic        ram_we,
   output logic [7:0]  ram_waddr,
   output logic [15:0] ram_wdata,
   output logic [15:0] ram_mask,
   output logic        ram_re,
   output logic [7:0]  ram_raddr,
   input  logic [15:0] ram_rdata
);

   localparam logic [8:0] Full = 9'(DEPTH);

   logic [7:0]  wptr_q, rptr_q;
   logic [8:0]  cnt_q, cnt_d;
   logic        inflight_q;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_data_q, out_data_d;
   logic        skid_valid_q, skid_valid_d;
   logic [15:0] skid_data_q, skid_data_d;

   logic        push, pop, fetch;
   logic [1:0]  occ, occ_after_pop;

   assign wr_ready = !reset && !clr && (cnt_q != Full);
   assign push     = wr_valid && wr_ready;
   assign pop      = out_valid_q && rd_ready;

   assign occ           = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
   assign occ_after_pop = occ - {1'b0, pop};
   // Fetch only while the stage can still absorb the returning word; a pointer
   // match implies cnt is 0 or full, so read and write never share an address.
   assign fetch = !reset && !clr && (cnt_q != 9'd0) && (occ_after_pop < 2'd2);

   assign ram_we    = push;
   assign ram_waddr = wptr_q;
   assign ram_wdata = wr_data;
   assign ram_mask  = 16'h0000;
   assign ram_re    = fetch;
   assign ram_raddr = rptr_q;

   assign rd_valid = out_valid_q;
   assign rd_data  = out_data_q;
   assign level    = cnt_q + {8'd0, out_valid_q} + {8'd0, skid_valid_q} + {8'd0, inflight_q};

   assign cnt_d = cnt_q + {8'd0, push} - {8'd0, fetch};

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (pop) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b0;
         end
      end
      // Returning word goes to out only if nothing older is ahead of it.
      if (inflight_q) begin
         if ((!out_valid_q || pop) && !skid_valid_q) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_rdata;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = ram_rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q       <= 8'd0;
         rptr_q       <= 8'd0;
         cnt_q        <= 9'd0;
         inflight_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= 16'd0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= 16'd0;
      end else if (clr) begin
         wptr_q       <= 8'd0;
         rptr_q       <= 8'd0;
         cnt_q        <= 9'd0;
         inflight_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + 8'd1;
         end
         if (fetch) begin
            rptr_q <= rptr_q + 8'd1;
         end
         cnt_q        <= cnt_d;
         inflight_q   <= fetch;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: tb/tb_ram4k_stream_fifo.sv
// Scoreboard bench for ram4k_stream_fifo with a behavioural RAM4K model.
module tb_ram4k_stream_fifo;

   logic        clk = 1'b0;
   logic        reset, clr;
   logic        wr_valid, wr_ready;
   logic [15:0] wr_data;
   logic        rd_valid, rd_ready;
   logic [15:0] rd_data;
   logic [8:0]  level;
   logic        ram_we, ram_re;
   logic [7:0]  ram_waddr, ram_raddr;
   logic [15:0] ram_wdata, ram_mask, ram_rdata;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] mem[256];

   always #5 clk = ~clk;

   ram4k_stream_fifo #(.DEPTH(256)) dut (
      .clk(clk), .reset(reset), .clr(clr),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .level(level),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_mask(ram_mask),
      .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
   );

   // RAM4K model: mask bit 0 = write enabled, registered read data
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= (ram_wdata & ~ram_mask) | (mem[ram_waddr] & ram_mask);
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, req, req, $time);
      end
   endtask

   // Monitor: push on accepted write, pop/compare on accepted read
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_valid && wr_ready) exp_q.push_back(wr_data);
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_underflow: got word 0x%0h expected none at %0t", rd_data, $time);
            end else begin
               check("sb_data", int'(rd_data), int'(exp_q.pop_front()));
            end
         end
         if (ram_we && ram_re) check("no_collision", int'(ram_waddr != ram_raddr), 1);
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      while (level != 9'd0 && n < 2000) begin
         next();
         n++;
      end
      check({name, "_drain_level"}, int'(level), 0);
      check({name, "_drain_sb"}, exp_q.size(), 0);
      rd_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      int bubbles, stalls, accepted, sent, n, got;
      reset = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_data = 16'd0; rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_wr_ready", int'(wr_ready), 0);
      check("rst_rd_valid", int'(rd_valid), 0);
      check("rst_rd_data", int'(rd_data), 0);
      check("rst_level", int'(level), 0);
      check("rst_ram_we", int'(ram_we), 0);
      check("rst_ram_re", int'(ram_re), 0);
      check("rst_waddr", int'(ram_waddr), 0);
      check("rst_raddr", int'(ram_raddr), 0);
      check("rst_mask", int'(ram_mask), 0);
      next();
      reset = 1'b0;
      @(negedge clk);
      check("rel_wr_ready", int'(wr_ready), 1);

      // Write 1..3, latency and level
      next(); wr_valid = 1'b1; wr_data = 16'h0001;
      next(); wr_data = 16'h0002;
      next(); wr_data = 16'h0003;
      @(negedge clk);
      check("t1_rd_valid_c2", int'(rd_valid), 0);
      next(); wr_valid = 1'b0;
      @(negedge clk);
      check("t1_rd_valid_c3", int'(rd_valid), 1);
      check("t1_rd_data_c3", int'(rd_data), 1);
      repeat (3) next();
      check("t1_level", int'(level), 3);
      check("t1_mask", int'(ram_mask), 0);
      drain("t1");

      // 1000-word continuous stream
      bubbles = 0; stalls = 0;
      rd_ready = 1'b1;
      for (int c = 0; c < 1006; c++) begin
         next();
         wr_valid = (c < 1000);
         wr_data  = 16'h1000 + 16'(c);
         @(negedge clk);
         if (c < 1000 && !wr_ready) stalls++;
         if (c >= 3 && c < 1003 && !rd_valid) bubbles++;
      end
      check("t2_wr_stalls", stalls, 0);
      check("t2_rd_bubbles", bubbles, 0);
      drain("t2");

      // Fill to 258 with rd_ready low
      accepted = 0;
      for (int c = 0; c < 300; c++) begin
         next();
         wr_valid = 1'b1;
         wr_data  = 16'h2000 + 16'(c);
         @(negedge clk);
         if (wr_valid && wr_ready) accepted++;
      end
      next(); wr_valid = 1'b0;
      repeat (2) next();
      check("t3_accepted", accepted, 258);
      check("t3_level_full", int'(level), 258);
      check("t3_wr_ready_full", int'(wr_ready), 0);
      next(); rd_ready = 1'b1;
      next(); rd_ready = 1'b0;
      @(negedge clk);
      got = int'(wr_ready);
      if (got == 0) begin
         next();
         @(negedge clk);
         got = int'(wr_ready);
      end
      check("t3_recover", got, 1);
      check("t3_level_after_pop", int'(level), 257);
      drain("t3");

      // 600 words with random stalls, pointers wrap
      sent = 0; n = 0;
      while (sent < 600 && n < 5000) begin
         next();
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_data  = 16'h3000 + 16'(sent);
         rd_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (wr_valid && wr_ready) sent++;
         n++;
      end
      check("t4_sent", sent, 600);
      drain("t4");

      // clr with level 10 and a read in flight
      for (int i = 0; i < 11; i++) begin
         next(); wr_valid = 1'b1; wr_data = 16'h5000 + 16'(i);
      end
      next(); wr_valid = 1'b0;
      repeat (3) next();
      check("t5_level_pre", int'(level), 11);
      rd_ready = 1'b1;
      next(); rd_ready = 1'b0;
      check("t5_level_inflight", int'(level), 10);
      clr = 1'b1; wr_valid = 1'b1; wr_data = 16'hdead;
      @(negedge clk);
      check("t5_clr_wr_ready", int'(wr_ready), 0);
      exp_q.delete();
      next(); clr = 1'b0; wr_valid = 1'b0;
      @(negedge clk);
      check("t5_post_rd_valid", int'(rd_valid), 0);
      check("t5_post_level", int'(level), 0);
      next(); wr_valid = 1'b1; wr_data = 16'h4444;
      next(); wr_data = 16'h5555;
      next(); wr_valid = 1'b0;
      n = 0;
      while (!rd_valid && n < 10) begin
         next();
         n++;
      end
      check("t5_first_word", int'(rd_data), 16'h4444);
      drain("t5");

      // Asynchronous reset mid-stream
      rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         next(); wr_valid = 1'b1; wr_data = 16'h6000 + 16'(i);
      end
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("t6_rd_valid", int'(rd_valid), 0);
      check("t6_level", int'(level), 0);
      check("t6_wr_ready", int'(wr_ready), 0);
      check("t6_ram_we", int'(ram_we), 0);
      check("t6_ram_re", int'(ram_re), 0);
      check("t6_raddr", int'(ram_raddr), 0);
      check("t6_waddr", int'(ram_waddr), 0);
      exp_q.delete();
      wr_valid = 1'b0; rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("t6_rel_level", int'(level), 0);
      check("t6_rel_rd_valid", int'(rd_valid), 0);
      check("t6_rel_wr_ready", int'(wr_ready), 1);
      rd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         next(); wr_valid = 1'b1; wr_data = 16'h7000 + 16'(i);
      end
      drain("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
